// File: rtl/grid_mem_reader.sv
// rtl/grid_mem_reader.sv - 1-bit occupancy grid with a 2-stage aligned read pipeline and a command port
// The grid is updated through valid/ready commands; clear-all sweeps one row per cycle.
module grid_mem_reader #(
  parameter int COLS = 20,
  parameter int ROWS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [9:0] h_cnt_in,
  input  logic [9:0] v_cnt_in,
  output logic       valid_out,
  output logic [9:0] h_cnt_out,
  output logic [9:0] v_cnt_out,
  output logic       mem_pixel,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_col,
  input  logic [3:0] cmd_row
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_CLRALL = 2'b11;

  state_t                       state_q, state_d;
  logic [3:0]                   clr_row_q, clr_row_d;
  logic [ROWS-1:0][COLS-1:0]    grid_q, grid_d;

  logic       s1_valid_q;
  logic [9:0] s1_h_q, s1_v_q;
  logic [4:0] s1_col_q, s1_row_q;
  logic       s2_valid_q;
  logic [9:0] s2_h_q, s2_v_q;
  logic       s2_pix_q;

  logic rd_bit;
  logic cmd_fire;
  logic cell_in_range;

  assign cmd_fire      = cmd_valid & cmd_ready;
  assign cell_in_range = (cmd_col < 5'(COLS)) && (cmd_row < 4'(ROWS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_row_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire && (cmd_op == OP_CLRALL)) begin
          state_d   = CLEAR;
          clr_row_d = '0;
        end
      end
      CLEAR: begin
        clr_row_d = clr_row_q + 4'd1;
        if (clr_row_q == 4'(ROWS - 1)) begin
          state_d   = IDLE;
          clr_row_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
  end

  // Out-of-range single-cell commands still handshake but leave the grid alone.
  always_comb begin
    grid_d = grid_q;
    if (state_q == CLEAR) begin
      grid_d[clr_row_q] = '0;
    end else if (cmd_fire && cell_in_range) begin
      case (cmd_op)
        OP_SET:    grid_d[cmd_row][cmd_col] = 1'b1;
        OP_CLR:    grid_d[cmd_row][cmd_col] = 1'b0;
        OP_TOGGLE: grid_d[cmd_row][cmd_col] = ~grid_q[cmd_row][cmd_col];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grid_q <= '0;
    end else begin
      grid_q <= grid_d;
    end
  end

  // Reads use the pre-write grid, so a write on the capture edge is seen one edge later.
  always_comb begin
    rd_bit = 1'b0;
    if ((s1_col_q < 5'(COLS)) && (s1_row_q < 5'(ROWS))) begin
      rd_bit = grid_q[s1_row_q[3:0]][s1_col_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
      s2_pix_q   <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      s1_h_q     <= h_cnt_in;
      s1_v_q     <= v_cnt_in;
      s1_col_q   <= h_cnt_in[9:5];
      s1_row_q   <= v_cnt_in[9:5];
      s2_valid_q <= s1_valid_q;
      s2_h_q     <= s1_h_q;
      s2_v_q     <= s1_v_q;
      s2_pix_q   <= rd_bit;
    end
  end

  assign valid_out = s2_valid_q;
  assign h_cnt_out = s2_h_q;
  assign v_cnt_out = s2_v_q;
  assign mem_pixel = s2_pix_q;

endmodule
